// File: rtl/corevx_ptw.sv
// rtl/corevx_ptw.sv - Sv32 two-level page-table walker that fills corevx_tlb on a miss
module corevx_ptw (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        resolve_request,
  input  logic [19:0] resolve_virtual_address,
  input  logic [21:0] satp_ppn,
  output logic        resolve_done,
  output logic        resolve_pagefault,
  output logic        resolve_accessfault,
  output logic [21:0] resolve_physical_address,
  output logic [7:0]  resolve_access_bits,
  output logic        mem_read,
  output logic [33:0] mem_address,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic        mem_error,
  output logic [1:0]  tlb_command,
  output logic [19:0] tlb_virtual_address_w,
  output logic [7:0]  tlb_accesstag_w,
  output logic [21:0] tlb_phys_w
);

  localparam logic [1:0] TLB_CMD_NONE  = 2'd0;
  localparam logic [1:0] TLB_CMD_WRITE = 2'd1;

  typedef enum logic [1:0] {IDLE, LVL1, LVL0, DONE} state_t;

  state_t      state_q, state_d;
  logic [19:0] va_q;
  logic [21:0] satp_q;
  logic [21:0] pte_ppn_q;
  logic [21:0] res_ppn_q, res_ppn_d;
  logic [7:0]  res_bits_q, res_bits_d;
  logic        pf_q, pf_d, af_q, af_d;
  logic        latch_req, latch_ptr;

  logic [21:0] pte_ppn;
  logic        pte_v, pte_r, pte_w, pte_x;
  logic        unused_rsw;

  assign pte_ppn    = mem_rdata[31:10];
  assign pte_v      = mem_rdata[0];
  assign pte_r      = mem_rdata[1];
  assign pte_w      = mem_rdata[2];
  assign pte_x      = mem_rdata[3];
  // RSW bits carry nothing the walker or TLB needs
  assign unused_rsw = ^mem_rdata[9:8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      va_q       <= '0;
      satp_q     <= '0;
      pte_ppn_q  <= '0;
      res_ppn_q  <= '0;
      res_bits_q <= '0;
      pf_q       <= 1'b0;
      af_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      res_ppn_q  <= res_ppn_d;
      res_bits_q <= res_bits_d;
      pf_q       <= pf_d;
      af_q       <= af_d;
      if (latch_req) begin
        va_q   <= resolve_virtual_address;
        satp_q <= satp_ppn;
      end
      if (latch_ptr) pte_ppn_q <= pte_ppn;
    end
  end

  always_comb begin
    state_d                  = state_q;
    res_ppn_d                = res_ppn_q;
    res_bits_d               = res_bits_q;
    pf_d                     = pf_q;
    af_d                     = af_q;
    latch_req                = 1'b0;
    latch_ptr                = 1'b0;
    mem_read                 = 1'b0;
    mem_address              = '0;
    resolve_done             = 1'b0;
    resolve_pagefault        = 1'b0;
    resolve_accessfault      = 1'b0;
    resolve_physical_address = '0;
    resolve_access_bits      = '0;
    tlb_command              = TLB_CMD_NONE;
    tlb_virtual_address_w    = '0;
    tlb_accesstag_w          = '0;
    tlb_phys_w               = '0;

    case (state_q)
      IDLE: begin
        if (resolve_request) begin
          latch_req  = 1'b1;
          pf_d       = 1'b0;
          af_d       = 1'b0;
          res_ppn_d  = '0;
          res_bits_d = '0;
          state_d    = LVL1;
        end
      end
      LVL1, LVL0: begin
        mem_read    = 1'b1;
        mem_address = (state_q == LVL1) ? {satp_q, va_q[19:10], 2'b00}
                                        : {pte_ppn_q, va_q[9:0], 2'b00};
        if (mem_ready) begin
          state_d = DONE;
          if (mem_error) begin
            af_d = 1'b1;
          end else if (!pte_v || (!pte_r && pte_w)) begin
            pf_d = 1'b1;
          end else if (pte_r || pte_x) begin
            if (state_q == LVL1 && pte_ppn[9:0] != 10'd0) begin
              pf_d = 1'b1;
            end else begin
              // a level-1 leaf maps a 4 MiB superpage, so VPN0 fills the low PPN bits
              res_ppn_d  = (state_q == LVL1) ? {pte_ppn[21:10], va_q[9:0]} : pte_ppn;
              res_bits_d = mem_rdata[7:0];
            end
          end else if (state_q == LVL1) begin
            latch_ptr = 1'b1;
            state_d   = LVL0;
          end else begin
            pf_d = 1'b1;
          end
        end
      end
      DONE: begin
        resolve_done        = 1'b1;
        resolve_pagefault   = pf_q;
        resolve_accessfault = af_q;
        state_d             = IDLE;
        if (!pf_q && !af_q) begin
          resolve_physical_address = res_ppn_q;
          resolve_access_bits      = res_bits_q;
          tlb_command              = TLB_CMD_WRITE;
          tlb_virtual_address_w    = va_q;
          tlb_accesstag_w          = res_bits_q;
          tlb_phys_w               = res_ppn_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
